// File: rtl/jt7759_adpcm_dec_if.sv
// Decoder-side bundle between the JT7759 control FSM and the ADPCM decoder.
// The control FSM drives the nibble stream and clear; the decoder returns PCM.
interface jt7759_adpcm_dec_if #(
  parameter int OUTW = 14
);
  logic            cen_dec;
  logic            dec_rst;
  logic [3:0]      dec_din;
  logic [OUTW-1:0] sound;
  logic            snd_ok;

  modport master (
    output cen_dec,
    output dec_rst,
    output dec_din,
    input  sound,
    input  snd_ok
  );

  modport slave (
    input  cen_dec,
    input  dec_rst,
    input  dec_din,
    output sound,
    output snd_ok
  );
endinterface

// File: rtl/jt7759_adpcm_dec.sv
// uPD7759 ADPCM decoder: adaptive step lookup (stage 1) followed by a
// saturating 9-bit accumulator (stage 2). Output is MSB-aligned into OUTW bits.
module jt7759_adpcm_dec #(
  parameter int OUTW = 14
) (
  input  logic               clk,
  input  logic               rst,
  jt7759_adpcm_dec_if.slave  dec
);

  // Step magnitudes per index row; nibble bit 3 selects the negated half.
  localparam logic [7:0] STEP_MAG [0:15][0:7] = '{
    '{8'd0, 8'd0,  8'd1,  8'd2,  8'd3,  8'd5,   8'd7,   8'd10 },
    '{8'd0, 8'd1,  8'd2,  8'd3,  8'd4,  8'd6,   8'd8,   8'd13 },
    '{8'd0, 8'd1,  8'd2,  8'd4,  8'd5,  8'd7,   8'd10,  8'd15 },
    '{8'd0, 8'd1,  8'd3,  8'd4,  8'd6,  8'd9,   8'd13,  8'd19 },
    '{8'd0, 8'd2,  8'd3,  8'd5,  8'd8,  8'd11,  8'd15,  8'd23 },
    '{8'd0, 8'd2,  8'd4,  8'd7,  8'd10, 8'd14,  8'd19,  8'd29 },
    '{8'd0, 8'd3,  8'd5,  8'd8,  8'd12, 8'd16,  8'd22,  8'd33 },
    '{8'd1, 8'd4,  8'd7,  8'd10, 8'd15, 8'd20,  8'd29,  8'd43 },
    '{8'd1, 8'd4,  8'd8,  8'd13, 8'd18, 8'd25,  8'd35,  8'd53 },
    '{8'd1, 8'd6,  8'd10, 8'd16, 8'd22, 8'd31,  8'd43,  8'd64 },
    '{8'd2, 8'd7,  8'd12, 8'd19, 8'd27, 8'd37,  8'd51,  8'd76 },
    '{8'd2, 8'd9,  8'd16, 8'd24, 8'd34, 8'd46,  8'd64,  8'd96 },
    '{8'd3, 8'd11, 8'd19, 8'd29, 8'd41, 8'd57,  8'd79,  8'd117},
    '{8'd4, 8'd13, 8'd24, 8'd36, 8'd50, 8'd69,  8'd96,  8'd143},
    '{8'd4, 8'd16, 8'd29, 8'd44, 8'd62, 8'd85,  8'd118, 8'd175},
    '{8'd6, 8'd20, 8'd36, 8'd54, 8'd76, 8'd106, 8'd148, 8'd217}
  };

  // Index adaptation by magnitude code; the sign bit does not matter.
  localparam logic signed [5:0] ADAPT [0:7] = '{
    -6'sd1, -6'sd1, 6'sd0, 6'sd0, 6'sd1, 6'sd2, 6'sd2, 6'sd3
  };

  logic signed [8:0]  r_acc;
  logic        [3:0]  r_idx;
  logic signed [8:0]  r_step;
  logic               r_pend;
  logic [OUTW-1:0]    r_sound;
  logic               r_snd_ok;

  logic        [7:0]  w_mag;
  logic signed [8:0]  w_step;
  logic signed [5:0]  w_idx_sum;
  logic        [3:0]  w_idx_next;
  logic signed [9:0]  w_sum;
  logic signed [8:0]  w_acc_next;
  logic [OUTW-1:0]    w_sound;

  // Step lookup and clamped index update for the nibble being sampled.
  always_comb begin
    w_mag     = STEP_MAG[r_idx][dec.dec_din[2:0]];
    w_step    = dec.dec_din[3] ? -$signed({1'b0, w_mag}) : $signed({1'b0, w_mag});
    w_idx_sum = $signed({2'b00, r_idx}) + ADAPT[dec.dec_din[2:0]];
    if (w_idx_sum < 0)
      w_idx_next = 4'd0;
    else if (w_idx_sum > 6'sd15)
      w_idx_next = 4'd15;
    else
      w_idx_next = w_idx_sum[3:0];
  end

  // Accumulate at 10 bits, saturate back to 9, and left-align into the output.
  always_comb begin
    w_sum = {r_acc[8], r_acc} + {r_step[8], r_step};
    if (w_sum > 10'sd255)
      w_acc_next = 9'sd255;
    else if (w_sum < -10'sd256)
      w_acc_next = -9'sd256;
    else
      w_acc_next = w_sum[8:0];
    w_sound = '0;
    w_sound[OUTW-1 -: 9] = w_acc_next;
  end

  // Two-stage pipeline; dec_rst clears state and drops any pending update.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_acc    <= '0;
      r_idx    <= '0;
      r_step   <= '0;
      r_pend   <= 1'b0;
      r_sound  <= '0;
      r_snd_ok <= 1'b0;
    end else if (dec.dec_rst) begin
      r_acc    <= '0;
      r_idx    <= '0;
      r_pend   <= 1'b0;
      r_sound  <= '0;
      r_snd_ok <= 1'b0;
    end else begin
      r_snd_ok <= 1'b0;
      if (r_pend) begin
        r_acc    <= w_acc_next;
        r_sound  <= w_sound;
        r_snd_ok <= 1'b1;
        r_pend   <= 1'b0;
      end
      if (dec.cen_dec) begin
        r_step <= w_step;
        r_idx  <= w_idx_next;
        r_pend <= 1'b1;
      end
    end
  end

  assign dec.sound  = r_sound;
  assign dec.snd_ok = r_snd_ok;

endmodule

// File: tb/tb_jt7759_adpcm_dec.sv
// Bench for the ADPCM decoder: directed scenarios plus a randomized nibble
// stream, all checked against an arithmetic model of the uPD7759 algorithm.
module tb_jt7759_adpcm_dec;

  localparam int OUTW  = 14;
  localparam int SCALE = 1 << (OUTW - 9);

  logic clk;
  logic rst;
  int   nCmp;
  int   nFail;
  int   mAcc;
  int   mIdx;

  // Full signed step table, row = index, column = nibble.
  int STEP_TBL [16][16] = '{
    '{0, 0, 1, 2, 3, 5, 7, 10, 0, 0, -1, -2, -3, -5, -7, -10},
    '{0, 1, 2, 3, 4, 6, 8, 13, 0, -1, -2, -3, -4, -6, -8, -13},
    '{0, 1, 2, 4, 5, 7, 10, 15, 0, -1, -2, -4, -5, -7, -10, -15},
    '{0, 1, 3, 4, 6, 9, 13, 19, 0, -1, -3, -4, -6, -9, -13, -19},
    '{0, 2, 3, 5, 8, 11, 15, 23, 0, -2, -3, -5, -8, -11, -15, -23},
    '{0, 2, 4, 7, 10, 14, 19, 29, 0, -2, -4, -7, -10, -14, -19, -29},
    '{0, 3, 5, 8, 12, 16, 22, 33, 0, -3, -5, -8, -12, -16, -22, -33},
    '{1, 4, 7, 10, 15, 20, 29, 43, -1, -4, -7, -10, -15, -20, -29, -43},
    '{1, 4, 8, 13, 18, 25, 35, 53, -1, -4, -8, -13, -18, -25, -35, -53},
    '{1, 6, 10, 16, 22, 31, 43, 64, -1, -6, -10, -16, -22, -31, -43, -64},
    '{2, 7, 12, 19, 27, 37, 51, 76, -2, -7, -12, -19, -27, -37, -51, -76},
    '{2, 9, 16, 24, 34, 46, 64, 96, -2, -9, -16, -24, -34, -46, -64, -96},
    '{3, 11, 19, 29, 41, 57, 79, 117, -3, -11, -19, -29, -41, -57, -79, -117},
    '{4, 13, 24, 36, 50, 69, 96, 143, -4, -13, -24, -36, -50, -69, -96, -143},
    '{4, 16, 29, 44, 62, 85, 118, 175, -4, -16, -29, -44, -62, -85, -118, -175},
    '{6, 20, 36, 54, 76, 106, 148, 217, -6, -20, -36, -54, -76, -106, -148, -217}
  };
  int ADAPT_TBL [8] = '{-1, -1, 0, 0, 1, 2, 2, 3};

  jt7759_adpcm_dec_if #(.OUTW(OUTW)) ifc ();

  jt7759_adpcm_dec #(.OUTW(OUTW)) dut (
    .clk (clk),
    .rst (rst),
    .dec (ifc.slave)
  );

  // Free-running clock, 10 time units per period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int clampInt(input int v, input int lo, input int hi);
    if (v < lo) return lo;
    if (v > hi) return hi;
    return v;
  endfunction

  function automatic int sndInt();
    return int'($signed(ifc.sound));
  endfunction

  function automatic int idxInt();
    return int'(dut.r_idx);
  endfunction

  // Reference: one nibble advances the accumulator then the index.
  task automatic modelNibble(input logic [3:0] n);
    mAcc = clampInt(mAcc + STEP_TBL[mIdx][n], -256, 255);
    mIdx = clampInt(mIdx + ADAPT_TBL[n[2:0]], 0, 15);
  endtask

  task automatic checkVal(input string tag, input int obs, input int exp);
    nCmp++;
    assert (obs === exp) else begin
      nFail++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Full output check against the model after a decoded sample lands.
  task automatic checkOutput(input string tag);
    checkVal({tag, "_sound"}, sndInt(), mAcc * SCALE);
    checkVal({tag, "_snd_ok"}, int'(ifc.snd_ok), 1);
    checkVal({tag, "_idx"}, idxInt(), mIdx);
  endtask

  // Send one nibble with minimum spacing and verify the resulting sample.
  task automatic applyStimulus(input logic [3:0] n, input string tag);
    @(negedge clk);
    checkVal({tag, "_pulse_end"}, int'(ifc.snd_ok), 0);
    ifc.cen_dec = 1'b1;
    ifc.dec_din = n;
    @(negedge clk);
    ifc.cen_dec = 1'b0;
    checkVal({tag, "_no_early"}, int'(ifc.snd_ok), 0);
    modelNibble(n);
    @(negedge clk);
    checkOutput(tag);
  endtask

  // Pulse dec_rst for one clock and verify the decoder is silent.
  task automatic clearDecoder(input string tag);
    @(negedge clk);
    ifc.dec_rst = 1'b1;
    @(negedge clk);
    checkVal({tag, "_sound"}, sndInt(), 0);
    checkVal({tag, "_snd_ok"}, int'(ifc.snd_ok), 0);
    checkVal({tag, "_idx"}, idxInt(), 0);
    ifc.dec_rst = 1'b0;
    mAcc = 0;
    mIdx = 0;
  endtask

  // Directed scenarios followed by a random stream, then the summary.
  initial begin
    nCmp = 0;
    nFail = 0;
    mAcc = 0;
    mIdx = 0;
    rst = 1'b1;
    ifc.cen_dec = 1'b0;
    ifc.dec_rst = 1'b1;
    ifc.dec_din = 4'd0;

    repeat (3) @(negedge clk);
    checkVal("rst_sound", sndInt(), 0);
    checkVal("rst_snd_ok", int'(ifc.snd_ok), 0);
    checkVal("rst_idx", idxInt(), 0);
    rst = 1'b0;

    // Held in dec_rst: cen_dec strobes must be ignored.
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      checkVal("decrst_snd_ok", int'(ifc.snd_ok), 0);
      checkVal("decrst_sound", sndInt(), 0);
      checkVal("decrst_idx", idxInt(), 0);
      ifc.cen_dec = ~ifc.cen_dec;
      ifc.dec_din = 4'd7;
    end
    @(negedge clk);
    ifc.cen_dec = 1'b0;
    ifc.dec_rst = 1'b0;

    // Single step from idx 0.
    applyStimulus(4'd7, "t2");
    checkVal("t2_acc_lit", sndInt(), 10 * SCALE);
    checkVal("t2_idx_lit", idxInt(), 3);

    // Index clamps at zero.
    clearDecoder("t3_clr");
    for (int i = 0; i < 5; i++) applyStimulus(4'd0, "t3_zero");
    applyStimulus(4'd8, "t3_neg0");
    checkVal("t3_acc_lit", sndInt(), 0);
    checkVal("t3_idx_lit", idxInt(), 0);

    // Positive and negative steps.
    applyStimulus(4'd4, "t4a");
    checkVal("t4a_lit", sndInt(), 3 * SCALE);
    applyStimulus(4'd4, "t4b");
    checkVal("t4b_lit", sndInt(), 7 * SCALE);
    applyStimulus(4'd9, "t4c");
    checkVal("t4c_lit", sndInt(), 6 * SCALE);
    checkVal("t4c_idx_lit", idxInt(), 1);

    // Saturation at both rails.
    for (int i = 0; i < 64; i++) applyStimulus(4'd7, "t5_pos");
    checkVal("t5_pos_lit", sndInt(), 255 * SCALE);
    checkVal("t5_idx_lit", idxInt(), 15);
    for (int i = 0; i < 16; i++) applyStimulus(4'hF, "t5_neg");
    checkVal("t5_neg_lit", sndInt(), -256 * SCALE);

    // Back-to-back cen_dec on consecutive clocks.
    clearDecoder("t6_clr");
    @(negedge clk);
    ifc.cen_dec = 1'b1;
    ifc.dec_din = 4'd7;
    @(negedge clk);
    ifc.dec_din = 4'd7;
    @(negedge clk);
    ifc.cen_dec = 1'b0;
    checkVal("t6_b2b_first", sndInt(), 10 * SCALE);
    checkVal("t6_b2b_ok1", int'(ifc.snd_ok), 1);
    @(negedge clk);
    checkVal("t6_b2b_second", sndInt(), 29 * SCALE);
    checkVal("t6_b2b_ok2", int'(ifc.snd_ok), 1);
    @(negedge clk);
    checkVal("t6_b2b_ok_end", int'(ifc.snd_ok), 0);

    // dec_rst while an update is pending drops it.
    @(negedge clk);
    ifc.cen_dec = 1'b1;
    ifc.dec_din = 4'd7;
    @(negedge clk);
    ifc.cen_dec = 1'b0;
    ifc.dec_rst = 1'b1;
    @(negedge clk);
    checkVal("t6_drop_sound", sndInt(), 0);
    checkVal("t6_drop_snd_ok", int'(ifc.snd_ok), 0);
    checkVal("t6_drop_idx", idxInt(), 0);

    // cen_dec in the same clock as dec_rst deassertion is ignored.
    ifc.cen_dec = 1'b1;
    ifc.dec_din = 4'd7;
    @(negedge clk);
    ifc.cen_dec = 1'b0;
    ifc.dec_rst = 1'b0;
    @(negedge clk);
    checkVal("t6_deassert_ok", int'(ifc.snd_ok), 0);
    checkVal("t6_deassert_idx", idxInt(), 0);
    mAcc = 0;
    mIdx = 0;
    applyStimulus(4'd5, "t6_first");

    // Random nibble stream with occasional clears and idle gaps.
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 24) == 0) begin
        clearDecoder("rnd_clr");
      end else begin
        applyStimulus(4'($urandom_range(0, 15)), "rnd");
      end
      repeat ($urandom_range(0, 2)) begin
        @(negedge clk);
        checkVal("rnd_idle_ok", int'(ifc.snd_ok), 0);
      end
    end

    // Asynchronous reset in the middle of a pending update.
    applyStimulus(4'd6, "rst_pre");
    @(negedge clk);
    ifc.cen_dec = 1'b1;
    ifc.dec_din = 4'd7;
    @(posedge clk);
    #2;
    ifc.cen_dec = 1'b0;
    rst = 1'b1;
    #1;
    checkVal("rst_mid_sound", sndInt(), 0);
    checkVal("rst_mid_idx", idxInt(), 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checkVal("rst_mid_ok", int'(ifc.snd_ok), 0);
    checkVal("rst_mid_sound2", sndInt(), 0);
    mAcc = 0;
    mIdx = 0;
    applyStimulus(4'd3, "rst_post");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nFail);
    $finish;
  end

endmodule
